// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types, constants and round-robin pick for the UART TX arbiter
//
// Purpose : arbiter FSM states, parity codes, default SEND timeout, and the
//           combinational round-robin selector used to pick the next client.
// Contents: state_e, parity_e, DEFAULT_TIMEOUT, RR_MAX, rr_pick()
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_ODD  = 2'b01,
    PARITY_EVEN = 2'b10
  } parity_e;

  localparam int DEFAULT_TIMEOUT = 4096;

  // Widest client count the selector handles; narrower request vectors are
  // zero-extended by the caller.
  localparam int RR_MAX = 8;

  // Rotate the request vector so that bit ptr lands at position 0, take the
  // lowest set bit, then rotate the index back. Only the low n bits take part.
  // With no request set the result is ptr, which the caller never uses.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [7:0] rot;
    logic [2:0] k;
    logic       found;
    int         src;
    rot   = '0;
    k     = '0;
    found = 1'b0;
    src   = 0;
    for (int i = 0; i < RR_MAX; i++) begin
      if (i < n) begin
        src          = (int'(ptr) + i) % n;
        rot[3'(i)]   = req[3'(src)];
      end
    end
    for (int i = 0; i < RR_MAX; i++) begin
      if (!found && rot[3'(i)]) begin
        found = 1'b1;
        k     = 3'(i);
      end
    end
    return 3'((int'(ptr) + int'(k)) % n);
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// rtl/uart_sync_edge.sv - two-flop synchronizer with optional rising-edge output
//
// Purpose : brings a signal from the baud domain into the system clock domain.
// Ports   : clock  in  system clock
//           rst    in  async reset, active-high
//           din    in  asynchronous input
//           dout   out synchronized level (EDGE_OUT=0) or one-cycle rising-edge
//                      pulse (EDGE_OUT=1)
module uart_sync_edge #(
  parameter bit EDGE_OUT = 1'b0
) (
  input  logic clock,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
    end
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic s3_q;
      always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
          s3_q <= 1'b0;
        end else begin
          s3_q <= s2_q;
        end
      end
      assign dout = s2_q & ~s3_q;
    end else begin : g_level
      assign dout = s2_q;
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART TX serializer among clients
//
// Purpose : grants NUM_REQ clients round-robin, latches the winner's byte and
//           line config, drives the serializer start, and reports per-client
//           ack / done / timeout error pulses.
// Ports   : clock, rst                 system clock, async active-high reset
//           req[NUM_REQ]               level requests, held until req_ack
//           req_data / req_parity_type / req_stop_bits / req_data_length
//                                      per-client payload and line config
//           req_ack / req_done / req_err
//                                      one-hot single-cycle pulses to the owner
//           tx_data, parity_type, stop_bits, data_length
//                                      latched payload/config to the TX path
//           send                       start level to the serializer
//           tx_active, tx_done         status from the baud domain (async)
//           busy                       arbiter not idle
//           owner                      current / last granted client
module uart_tx_arbiter
  import uart_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*2-1:0]         req_parity_type,
  input  logic [NUM_REQ-1:0]           req_stop_bits,
  input  logic [NUM_REQ-1:0]           req_data_length,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_err,
  output logic [DATA_W-1:0]            tx_data,
  output logic [1:0]                   parity_type,
  output logic                         stop_bits,
  output logic                         data_length,
  output logic                         send,
  input  logic                         tx_active,
  input  logic                         tx_done,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner
);

  localparam int OW    = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic tx_active_sync;
  logic tx_done_rise;

  uart_sync_edge #(.EDGE_OUT(1'b0)) u_sync_active (
    .clock (clock),
    .rst   (rst),
    .din   (tx_active),
    .dout  (tx_active_sync)
  );

  uart_sync_edge #(.EDGE_OUT(1'b1)) u_sync_done (
    .clock (clock),
    .rst   (rst),
    .din   (tx_done),
    .dout  (tx_done_rise)
  );

  state_e               state_q,   state_d;
  logic [OW-1:0]        ptr_q,     ptr_d;
  logic [OW-1:0]        cand_q,    cand_d;
  logic [OW-1:0]        owner_q,   owner_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic [1:0]           parity_q,  parity_d;
  logic                 stop_q,    stop_d;
  logic                 len_q,     len_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 send_q,    send_d;
  logic                 busy_q,    busy_d;
  logic [NUM_REQ-1:0]   ack_q,     ack_d;
  logic [NUM_REQ-1:0]   done_q,    done_d;
  logic [NUM_REQ-1:0]   err_q,     err_d;

  logic [OW-1:0]        pick;
  logic [OW-1:0]        ptr_after_owner;

  assign pick            = OW'(rr_pick(8'(req), 3'(ptr_q), NUM_REQ));
  // The pointer moves past the owner whether the frame finished or timed out,
  // so a client whose frames keep failing cannot hog the serializer.
  assign ptr_after_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cand_d    = cand_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    parity_d  = parity_q;
    stop_d    = stop_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    send_d    = send_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;

    case (state_q)
      ST_IDLE: begin
        send_d = 1'b0;
        if (|req) begin
          cand_d  = pick;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // Config is captured only here, so it holds steady for the whole
        // frame and up to the next grant.
        owner_d         = cand_q;
        tx_data_d       = req_data[int'(cand_q)*DATA_W +: DATA_W];
        parity_d        = req_parity_type[int'(cand_q)*2 +: 2];
        stop_d          = req_stop_bits[cand_q];
        len_d           = req_data_length[cand_q];
        ack_d[cand_q]   = 1'b1;
        cnt_d           = '0;
        send_d          = 1'b1;
        state_d         = ST_SEND;
      end

      ST_SEND: begin
        if (tx_active_sync) begin
          send_d  = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d[owner_q] = 1'b1;
          send_d         = 1'b0;
          ptr_d          = ptr_after_owner;
          state_d        = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        send_d = 1'b0;
        // Only a done edge seen here is credited; edges in earlier states
        // belong to no current frame.
        if (tx_done_rise) begin
          done_d[owner_q] = 1'b1;
          ptr_d           = ptr_after_owner;
          state_d         = ST_IDLE;
        end
      end

      default: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cand_q    <= '0;
      owner_q   <= '0;
      tx_data_q <= '0;
      parity_q  <= PARITY_NONE;
      stop_q    <= 1'b0;
      len_q     <= 1'b0;
      cnt_q     <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cand_q    <= cand_d;
      owner_q   <= owner_d;
      tx_data_q <= tx_data_d;
      parity_q  <= parity_d;
      stop_q    <= stop_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign req_err     = err_q;
  assign tx_data     = tx_data_q;
  assign parity_type = parity_q;
  assign stop_bits   = stop_q;
  assign data_length = len_q;
  assign send        = send_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule
